// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared encodings and constants for the countdown timer.
//   ST_*     : FSM state encodings; the same values are driven on the status
//              port (00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED).
//   MAX_SEC  : largest legal seconds value.
//   clamp_sec: limits a preset seconds value to MAX_SEC.
// ---------------------------------------------------------------------------
package timer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'b00;
  localparam state_t ST_RUNNING = 2'b01;
  localparam state_t ST_PAUSED  = 2'b10;
  localparam state_t ST_EXPIRED = 2'b11;

  localparam logic [5:0] MAX_SEC = 6'd59;

  function automatic logic [5:0] clamp_sec(input logic [5:0] s);
    return (s > MAX_SEC) ? MAX_SEC : s;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// ---------------------------------------------------------------------------
// sec_tick_gen
// Prescaler producing a one-cycle sec_tick every TICKS_PER_SEC enabled cycles.
//   clk      : clock (rising edge)
//   rst      : synchronous active-high reset, zeroes the prescaler
//   enable   : advance the prescaler this cycle
//   clr      : zero the prescaler (takes precedence over enable)
//   sec_tick : high when enabled and the prescaler sits on its terminal value
// While enable is low the prescaler holds, so a paused count resumes from
// exactly where it stopped.
// ---------------------------------------------------------------------------
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clr,
  output logic sec_tick
);

  // A one-bit counter is kept even for TICKS_PER_SEC == 1; it then never
  // leaves zero and every enabled cycle is a tick.
  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          terminal;

  assign terminal = (cnt_q == TERM);
  assign sec_tick = enable && terminal;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = terminal ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
// Minutes:seconds countdown timer with load / start / stop / clear commands.
//   clk               : clock (rising edge)
//   rst               : synchronous active-high reset
//   load              : preset count from load_min / load_sec (seconds clamped)
//   load_min[7:0]     : preset minutes
//   load_sec[5:0]     : preset seconds
//   start             : begin or resume counting
//   stop              : pause counting
//   clear             : return to IDLE at 00:00
//   minutes[7:0]      : remaining minutes (registered)
//   seconds[5:0]      : remaining seconds 0..59 (registered)
//   status[1:0]       : registered FSM state
//   done              : one-cycle pulse on reaching 00:00 while running
// Only the highest-priority active command (clear > load > stop > start) is
// considered each cycle; if that command is not legal in the current state
// it is simply ignored and lower-priority commands stay masked.
// ---------------------------------------------------------------------------
module countdown_timer
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [7:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] status,
  output logic       done
);

  state_t     state_q, state_d;
  logic [7:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       done_q, done_d;

  logic is_running;
  logic count_zero;
  logic load_ok;
  logic stop_act;
  logic start_act;
  logic tick_en;
  logic pre_clr;
  logic sec_tick;

  // Command arbitration: each command is live only if no higher one is.
  assign is_running = (state_q == ST_RUNNING);
  assign count_zero = (min_q == 8'd0) && (sec_q == 6'd0);
  assign load_ok    = load && !clear && !is_running;
  assign stop_act   = stop && !clear && !load;
  assign start_act  = start && !clear && !load && !stop;

  // The prescaler freezes on a stop so that a coincident tick is dropped and
  // the partial second is kept for the resume.
  assign tick_en = is_running && !clear && !stop_act;
  assign pre_clr = clear || load_ok;

  sec_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_sec_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .enable  (tick_en),
    .clr     (pre_clr),
    .sec_tick(sec_tick)
  );

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    done_d  = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      min_d   = 8'd0;
      sec_d   = 6'd0;
    end else if (load_ok) begin
      state_d = ST_IDLE;
      min_d   = load_min;
      sec_d   = clamp_sec(load_sec);
    end else if (stop_act && is_running) begin
      state_d = ST_PAUSED;
    end else if (start_act && (state_q == ST_IDLE || state_q == ST_PAUSED) && !count_zero) begin
      state_d = ST_RUNNING;
    end else if (sec_tick && !count_zero) begin
      // sec_tick only fires while running, and running is only entered with
      // a nonzero count; the count_zero guard keeps underflow impossible.
      if (sec_q != 6'd0) begin
        sec_d = sec_q - 6'd1;
      end else begin
        min_d = min_q - 8'd1;
        sec_d = MAX_SEC;
      end
      if (min_q == 8'd0 && sec_q == 6'd1) begin
        state_d = ST_EXPIRED;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      min_q   <= 8'd0;
      sec_q   <= 6'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      done_q  <= done_d;
    end
  end

  assign minutes = min_q;
  assign seconds = sec_q;
  assign status  = state_q;
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
// Directed scenarios followed by random commands. Every cycle the reference
// model (remaining time kept as a plain total-seconds integer) predicts the
// outputs after the coming edge and queues them; a monitor pops and compares
// after each rising edge. A few direct checks against fixed values are made
// at scenario milestones.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int TPS = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_min = 8'd0;
  logic [5:0] load_sec = 6'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] minutes;
  logic [5:0] seconds;
  logic [1:0] status;
  logic       done;

  always #5 clk = ~clk;

  countdown_timer #(.TICKS_PER_SEC(TPS)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_min(load_min),
    .load_sec(load_sec),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .minutes (minutes),
    .seconds (seconds),
    .status  (status),
    .done    (done)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] mi;
    logic [5:0] se;
    logic       dn;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: status code, remaining seconds, prescaler position.
  int m_state = 0;   // 0 idle, 1 running, 2 paused, 3 expired
  int m_rem   = 0;
  int m_pre   = 0;
  int m_done  = 0;

  task automatic model_step(input logic r, c, l, input logic [7:0] lm,
                            input logic [5:0] ls, input logic sp, st);
    bit run;
    int sec_val;
    run    = (m_state == 1);
    m_done = 0;
    if (r) begin
      m_state = 0; m_rem = 0; m_pre = 0; run = 0;
    end else if (c) begin
      m_state = 0; m_rem = 0; m_pre = 0; run = 0;
    end else if (l) begin
      if (m_state != 1) begin
        sec_val = (int'(ls) > 59) ? 59 : int'(ls);
        m_rem   = int'(lm) * 60 + sec_val;
        m_pre   = 0;
        m_state = 0;
      end
    end else if (sp) begin
      if (m_state == 1) begin
        m_state = 2; run = 0;
      end
    end else if (st) begin
      if ((m_state == 0 || m_state == 2) && m_rem > 0) m_state = 1;
    end
    if (run) begin
      if (m_pre == TPS - 1) begin
        m_pre = 0;
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_state = 3; m_done = 1;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
  endtask

  // One clock cycle: drive inputs, run the model, queue the prediction.
  task automatic step(input string nm, input logic r, c, l, input logic [7:0] lm,
                      input logic [5:0] ls, input logic sp, st);
    exp_t e;
    @(negedge clk);
    rst = r; clear = c; load = l; load_min = lm; load_sec = ls; stop = sp; start = st;
    model_step(r, c, l, lm, ls, sp, st);
    e.st = 2'(m_state);
    e.mi = 8'(m_rem / 60);
    e.se = 6'(m_rem % 60);
    e.dn = 1'(m_done);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input string nm);
    step(nm, 0, 0, 0, 8'd0, 6'd0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_val(input string nm, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endtask

  // Monitor: after each rising edge compare the oldest queued prediction.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if (status == e.st && minutes == e.mi && seconds == e.se && done == e.dn) begin
          n_pass++;
        end else begin
          $display("FAIL %s: status/min/sec/done got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                   nm, status, minutes, seconds, done, e.st, e.mi, e.se, e.dn);
        end
      end
    end
  end

  initial begin
    int  done_cnt;
    bit  seen_wrap;
    bit  r, c, l, sp, st;
    logic [7:0] lm;
    logic [5:0] ls;

    // Reset for two cycles.
    step("reset", 1, 0, 0, 8'd0, 6'd0, 0, 0);
    step("reset", 1, 0, 0, 8'd0, 6'd0, 0, 0);
    settle();
    check_val("reset_status", int'(status), 0);
    check_val("reset_min", int'(minutes), 0);
    check_val("reset_sec", int'(seconds), 0);
    check_val("reset_done", int'(done), 0);

    // Load 01:02 and run to expiry.
    step("load_0102", 0, 0, 1, 8'd1, 6'd2, 0, 0);
    step("start_0102", 0, 0, 0, 8'd0, 6'd0, 0, 1);
    done_cnt  = 0;
    seen_wrap = 0;
    for (int i = 0; i < 62; i++) begin
      idle("run_0102");
      settle();
      if (done) done_cnt++;
      if (minutes == 8'd0 && seconds == 6'd59) seen_wrap = 1;
    end
    check_val("run62_status", int'(status), 3);
    check_val("run62_count", int'(minutes) * 60 + int'(seconds), 0);
    check_val("run62_wrap_0059", int'(seen_wrap), 1);
    idle("expired_hold");
    idle("expired_hold");
    settle();
    if (done) done_cnt++;
    check_val("done_pulses", done_cnt, 1);
    check_val("expired_hold_status", int'(status), 3);

    // Pause and resume.
    step("load_0010", 0, 0, 1, 8'd0, 6'd10, 0, 0);
    step("start_0010", 0, 0, 0, 8'd0, 6'd0, 0, 1);
    repeat (3) idle("run_0010");
    step("stop_0010", 0, 0, 0, 8'd0, 6'd0, 1, 0);
    idle("paused_hold");
    idle("paused_hold");
    settle();
    check_val("paused_status", int'(status), 2);
    check_val("paused_sec", int'(seconds), 7);
    step("resume", 0, 0, 0, 8'd0, 6'd0, 0, 1);
    repeat (7) idle("run_resume");
    settle();
    check_val("resume_expired", int'(status), 3);

    // Start at zero, clamp, load while running.
    step("clear", 0, 1, 0, 8'd0, 6'd0, 0, 0);
    step("start_zero", 0, 0, 0, 8'd0, 6'd0, 0, 1);
    settle();
    check_val("start_zero_status", int'(status), 0);
    step("load_clamp", 0, 0, 1, 8'd0, 6'd63, 0, 0);
    settle();
    check_val("clamp_sec", int'(seconds), 59);
    step("start_clamp", 0, 0, 0, 8'd0, 6'd0, 0, 1);
    step("load_running", 0, 0, 1, 8'd5, 6'd5, 0, 0);
    settle();
    check_val("load_running_ignored", int'(minutes) * 60 + int'(seconds), 58);

    // Clear beats start while running; reset mid-count.
    step("clear2", 0, 1, 0, 8'd0, 6'd0, 0, 0);
    step("load_0008", 0, 0, 1, 8'd0, 6'd8, 0, 0);
    step("start_0008", 0, 0, 0, 8'd0, 6'd0, 0, 1);
    repeat (3) idle("run_0008");
    step("clear_start", 0, 1, 0, 8'd0, 6'd0, 0, 1);
    settle();
    check_val("clear_start_status", int'(status), 0);
    check_val("clear_start_count", int'(minutes) * 60 + int'(seconds), 0);
    step("load_0009", 0, 0, 1, 8'd0, 6'd9, 0, 0);
    step("start_0009", 0, 0, 0, 8'd0, 6'd0, 0, 1);
    repeat (2) idle("run_0009");
    step("rst_mid", 1, 0, 0, 8'd0, 6'd0, 0, 0);
    settle();
    check_val("rst_mid_status", int'(status), 0);
    check_val("rst_mid_count", int'(minutes) * 60 + int'(seconds), 0);
    check_val("rst_mid_done", int'(done), 0);

    // Maximum count, then stop on a tick.
    step("load_max", 0, 0, 1, 8'd255, 6'd59, 0, 0);
    step("start_max", 0, 0, 0, 8'd0, 6'd0, 0, 1);
    repeat (60) idle("run_max");
    settle();
    check_val("max_min", int'(minutes), 254);
    check_val("max_sec", int'(seconds), 59);
    step("stop_on_tick", 0, 0, 0, 8'd0, 6'd0, 1, 0);
    settle();
    check_val("stop_tick_min", int'(minutes), 254);
    check_val("stop_tick_sec", int'(seconds), 59);
    check_val("stop_tick_status", int'(status), 2);

    // Random commands.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom % 200) == 0;
      c  = ($urandom % 40) == 0;
      l  = ($urandom % 12) == 0;
      sp = ($urandom % 15) == 0;
      st = ($urandom % 5) == 0;
      lm = (($urandom % 4) == 0) ? 8'($urandom % 256) : 8'($urandom % 2);
      ls = 6'($urandom % 64);
      step("random", r, c, l, lm, ls, sp, st);
    end
    idle("drain");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 100000000, giving clk cycles per counted second (benches use 1).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port load, input, 1, a one-cycle request to preset the count from load_min/load_sec.
REQ-005 The block SHALL have ports load_min, input, 8, and load_sec, input, 6, the preset values (load_sec above 59 is clamped to 59).
REQ-006 The block SHALL have port start, input, 1, a one-cycle request to begin or resume counting down.
REQ-007 The block SHALL have port stop, input, 1, a one-cycle request to pause.
REQ-008 The block SHALL have port clear, input, 1, a one-cycle request to return to IDLE at 00:00.
REQ-009 The block SHALL have ports minutes, output, 8, and seconds, output, 6, the remaining time (seconds 0..59).
REQ-010 The block SHALL have port status, output, 2: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED.
REQ-011 The block SHALL have port done, output, 1, a single-cycle pulse when the count reaches 00:00 while RUNNING.

Function
REQ-012 FSM states SHALL be IDLE, RUNNING, PAUSED and EXPIRED; status SHALL reflect the registered state.
REQ-013 Command priority in a cycle SHALL be clear > load > stop > start; only the highest active command acts.
REQ-014 clear SHALL, from any state, zero minutes and seconds, zero the prescaler and enter IDLE on the next edge.
REQ-015 load SHALL be accepted in IDLE, PAUSED and EXPIRED; it loads the count, zeroes the prescaler and enters IDLE. It is ignored while RUNNING.
REQ-016 start in IDLE or PAUSED with a nonzero count SHALL enter RUNNING on the next edge; start with count 00:00, or in RUNNING/EXPIRED, SHALL be ignored.
REQ-017 stop in RUNNING SHALL enter PAUSED; the count and prescaler SHALL hold and resume from the same values. stop in any other state SHALL be ignored.
REQ-018 While RUNNING, the prescaler SHALL count 0..TICKS_PER_SEC-1 and emit a one-cycle sec_tick on its terminal value.
REQ-019 On sec_tick, if seconds>0 then seconds decrements; else minutes decrements and seconds becomes 59.
REQ-020 When a decrement yields 00:00, the same edge SHALL enter EXPIRED and assert done for exactly that one cycle.
REQ-021 In EXPIRED the count SHALL hold at 00:00 until clear or load.
REQ-022 No underflow SHALL occur; minutes never wraps below 0 and seconds never exceeds 59.
REQ-023 If stop coincides with a sec_tick, stop SHALL win: no decrement and no done.
REQ-024 Maximum count SHALL be 255:59; with TICKS_PER_SEC=1 one decrement SHALL occur per RUNNING cycle.

Reset
REQ-025 While rst is high at a clock edge, state SHALL become IDLE, minutes and seconds 0, the prescaler 0 and done 0, overriding all commands, including mid-count.
REQ-026 After rst deasserts, the first command SHALL be honoured at the next edge.

Structure
REQ-027 Package timer_pkg SHALL hold the state/status encodings (ST_IDLE, ST_RUNNING, ST_PAUSED, ST_EXPIRED) and constant MAX_SEC=59.
REQ-028 Prescaler SHALL be sub-module sec_tick_gen (parameter TICKS_PER_SEC; inputs clk, rst, enable, clr; output sec_tick).
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification (TICKS_PER_SEC=1)
REQ-030 rst high for 2 cycles -> status=00, minutes=0, seconds=0, done=0.
REQ-031 Load 01:02 then start -> after 62 RUNNING cycles minutes:seconds passes 01:00 -> 00:59 and reaches 00:00 with done high for exactly 1 cycle and status=11.
REQ-032 Load 00:10, start, stop after 3 cycles -> status=10 holding 00:07; start again -> counting resumes from 00:07 and expires 7 cycles later.
REQ-033 Start with count 00:00 -> status stays 00; load_sec=63 -> seconds=59; load while RUNNING -> ignored.
REQ-034 Assert clear and start in the same cycle while RUNNING at 00:05 -> status=00, 00:00; assert rst mid-count -> status=00, 00:00, done=0.
REQ-035 Load 255:59, run 60 cycles -> 254:59; stop and tick in the same cycle -> no decrement.
